// File: rtl/mem_request_arbiter_if.sv
// mem_request_arbiter_if: client request bus plus memory controller port shared by the arbiter
interface mem_request_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_grant;
  logic [NUM_REQ-1:0]            req_done;
  logic [NUM_REQ-1:0]            req_error;
  logic [DATA_WIDTH-1:0]         req_rdata;
  logic                          busy;
  logic                          mem_read;
  logic                          mem_write;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic                          mem_ready;
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_grant, req_done, req_error, req_rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_grant, req_done, req_error, req_rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: round-robin sharing of one memory controller port with a completion watchdog
module mem_request_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 256
) (
  input logic clk,
  input logic reset,
  mem_request_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         ptr_q, id_q, win, idx;
  logic                  wr_q, err_q, timeout_hit;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [TW-1:0]         timer_q;
  logic [NUM_REQ-1:0]    id_oh;
  // Scan farthest-to-nearest from ptr+1 so the nearest asserted request overrides.
  always_comb begin
    win = ptr_q;
    idx = ptr_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((32'(ptr_q) + k) % NUM_REQ);
      win = bus.req_valid[idx] ? idx : win;
    end
  end
  assign id_oh       = NUM_REQ'(1) << id_q;
  assign timeout_hit = timer_q == TW'(TIMEOUT - 1);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.req_rdata = rdata_q;
  always_comb begin
    state_d = state_q == IDLE  ? (|bus.req_valid ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? ((bus.mem_ready || timeout_hit) ? DONE : WAIT) : IDLE;
    bus.req_grant = state_q == ISSUE ? id_oh : '0;
    bus.req_done  = (state_q == DONE && !err_q) ? id_oh : '0;
    bus.req_error = (state_q == DONE && err_q) ? id_oh : '0;
    bus.mem_read  = state_q == ISSUE && !wr_q;
    bus.mem_write = state_q == ISSUE && wr_q;
    bus.busy      = state_q != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      id_q    <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |bus.req_valid) begin
        id_q    <= win;
        ptr_q   <= win;
        wr_q    <= bus.req_write[win];
        addr_q  <= bus.req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= bus.req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state_q == ISSUE) timer_q <= '0;
      if (state_q == WAIT) begin
        if (bus.mem_ready) begin
          err_q <= 1'b0;
          if (!wr_q) rdata_q <= bus.mem_rdata;
        end else if (timeout_hit) err_q <= 1'b1;
        else timer_q <= timer_q + 1'b1;
      end
    end
  end
endmodule

// File: doc/mem_request_arbiter.md
# mem_request_arbiter

Round-robin arbiter that shares the single `memory_controller` port between NUM_REQ accelerator clients, such as the weight loader, activation loader and output writer. It accepts one request at a time, drives a one-cycle read or write command into the controller, and waits for the controller's `mem_ready` pulse. It then returns completion, with read data, to the granted client. A watchdog aborts transactions the controller never completes.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- DATA_WIDTH, 32, data width (matches memory_controller)
- ADDR_WIDTH, 16, address width (matches memory_controller)
- TIMEOUT, 256, max cycles in WAIT before abort (≥2)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-client request; held with fields stable until that client's grant
- req_write  in  NUM_REQ  1=write, 0=read, per client
- req_addr  in  NUM_REQ*ADDR_WIDTH  client i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  client i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_grant  out  NUM_REQ  one-hot pulse: request accepted
- req_done  out  NUM_REQ  one-hot pulse: transaction completed
- req_error  out  NUM_REQ  one-hot pulse: transaction aborted by timeout
- req_rdata  out  DATA_WIDTH  read data, valid with req_done of a read
- busy  out  1  high whenever state ≠ IDLE
- mem_read  out  1  to controller, one-cycle pulse
- mem_write  out  1  to controller, one-cycle pulse
- mem_addr  out  ADDR_WIDTH  to controller
- mem_wdata  out  DATA_WIDTH  to controller
- mem_rdata  in  DATA_WIDTH  from controller
- mem_ready  in  1  from controller, one-cycle completion pulse

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE → ISSUE when any req_valid is high.
  - Winner: first asserted index searching from ptr+1, wrapping modulo NUM_REQ.
  - On that edge, latch winner id, req_write, req_addr and req_wdata into internal registers.
  - On that edge, set ptr ← id.
- ISSUE → WAIT unconditionally.
  - During ISSUE: req_grant[id]=1, and mem_read=!wr_q or mem_write=wr_q.
  - The timer clears on entry to WAIT.
- WAIT:
  - If mem_ready=1, go to DONE with err_q=0. On a read, capture mem_rdata into req_rdata.
  - Else if timer == TIMEOUT-1, go to DONE with err_q=1.
  - Else increment timer.
- DONE → IDLE unconditionally. Assert req_done[id] if err_q=0, otherwise req_error[id].
- mem_addr and mem_wdata are driven from the latched registers at all times. They hold their last value in IDLE.
- All command, grant, done and error outputs decode from the registered state and id. They are glitch-free, with no combinational path from req_* inputs.
- req_rdata holds until the next completed read. It is unchanged by writes and by timeouts.
- Timer width is $clog2(TIMEOUT).

## Timing
- Reset values:
  - state=IDLE, ptr=NUM_REQ-1, so client 0 wins first.
  - req_grant, req_done and req_error = 0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - req_rdata=0, busy=0, timer=0, err_q=0.
- Latency:
  - req_valid sampled at edge T → grant and command during cycle T+1.
  - mem_ready sampled at edge M → req_done during cycle M+1.
  - At least one IDLE cycle separates transactions, which guarantees the controller has returned to IDLE.
- Handshake:
  - A client may drop req_valid the cycle after its grant.
  - Non-granted clients keep req_valid high and wait.
  - A client may reassert in the cycle after req_done; it is arbitrated against the others using the updated ptr.
- Boundary conditions:
  - mem_ready in IDLE, ISSUE or DONE is ignored. This covers a late pulse after a timeout abort.
  - mem_ready on the same cycle the timer reaches TIMEOUT-1: completion wins, no error.
  - All NUM_REQ clients asserting continuously are served strictly in rotation: 0,1,2,0,…
  - Single requester repeating: served back-to-back, one transaction per 4+ cycles.
  - Reset asserted in any state: all registers return to reset values on that edge and the in-flight transaction is dropped. No done or error pulse is generated.
  - A req_valid for an out-of-range index cannot exist by construction. ptr wraps NUM_REQ-1 → 0.

## Test plan
- Single read, client 1, addr 0x0040, model returns 0xDEADBEEF after 3 cycles:
  - grant[1] one cycle after valid, with mem_read=1 for exactly one cycle and mem_addr=0x0040.
  - done[1] one cycle after mem_ready, with req_rdata=0xDEADBEEF.
- Write, client 0, addr 0x1234, data 0xA5A5A5A5:
  - mem_write pulse with matching addr and data.
  - done[0] follows; req_rdata unchanged from the prior read.
- All three clients request continuously for 6 transactions:
  - Grant order 0,1,2,0,1,2; exactly one grant, done and error bit active at a time.
  - mem_read/mem_write never asserted while busy outside ISSUE.
- Model never asserts mem_ready, TIMEOUT=8:
  - req_error[id] is asserted 8 cycles after entering WAIT, and done is not asserted.
  - A later mem_ready pulse in IDLE is ignored; the next request proceeds normally.
- mem_ready arrives exactly on the final timeout cycle:
  - done asserted, error not asserted, rdata captured.
- Reset asserted during WAIT:
  - The next cycle shows all outputs at reset values and busy=0.
  - The next request from client 2 with client 0 also active grants client 0 first.
